// File: rtl/arq_pkg.sv
// Shared encodings for the stop-and-wait ARQ sender: FSM states, core error-injection
// modes, and a width helper for small counters.
package arq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_SINGLE = 2'b01;
   localparam logic [1:0] ERR_DOUBLE = 2'b10;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arq_tx_ctrl_if.sv
// Source handshake, core link and delivery signals of the ARQ sender.
// master = the sender itself, slave = the environment (source, core, sink).
interface arq_tx_ctrl_if #(parameter int DATA_WIDTH = 8);
   logic                  src_valid;
   logic                  src_ready;
   logic [DATA_WIDTH-1:0] src_data;
   logic [1:0]            inj_mode;
   logic                  link_wr_en;
   logic                  link_rd_en;
   logic [DATA_WIDTH-1:0] link_data;
   logic [1:0]            link_err_mode;
   logic [DATA_WIDTH-1:0] link_rx_data;
   logic                  link_ack;
   logic                  link_nack;
   logic                  dlv_valid;
   logic [DATA_WIDTH-1:0] dlv_data;
   logic                  fail;

   modport master (
      input  src_valid, src_data, inj_mode, link_rx_data, link_ack, link_nack,
      output src_ready, link_wr_en, link_rd_en, link_data, link_err_mode,
             dlv_valid, dlv_data, fail
   );

   modport slave (
      output src_valid, src_data, inj_mode, link_rx_data, link_ack, link_nack,
      input  src_ready, link_wr_en, link_rd_en, link_data, link_err_mode,
             dlv_valid, dlv_data, fail
   );
endinterface

// File: rtl/arq_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module arq_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    count <= '0;
      else if (inc && (count != '1)) count <= count + 1'b1;
   end

endmodule

// File: rtl/arq_tx_ctrl.sv
// Stop-and-wait ARQ sender feeding the ECC FIFO core: write, read back, await ack/nack,
// retransmit clean copies up to MAX_RETRY times. ARQ_STATS_EN adds retry/fail counters.
module arq_tx_ctrl
   import arq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 8,
   parameter int MAX_RETRY  = 3
`ifdef ARQ_STATS_EN
   ,
   parameter int CNT_W      = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   arq_tx_ctrl_if.master    bus,
   output logic             busy
`ifdef ARQ_STATS_EN
   ,
   output logic [CNT_W-1:0] retry_cnt,
   output logic [CNT_W-1:0] fail_cnt
`endif
);

   localparam int AW = cnt_width(MAX_RETRY + 1);
   localparam int TW = cnt_width(TIMEOUT);

   state_t                state, state_d;
   logic [DATA_WIDTH-1:0] hold_q;
   logic [1:0]            inj_q;
   logic [AW-1:0]         attempt;
   logic [TW-1:0]         timer;
   logic                  dlv_valid_q, fail_q;
   logic [DATA_WIDTH-1:0] dlv_data_q;
   logic                  load, deliver, give_up, retry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Ack outranks nack; the retry limit is checked before attempt can advance.
   always_comb begin
      state_d = state;
      load    = 1'b0;
      deliver = 1'b0;
      give_up = 1'b0;
      retry   = 1'b0;
      case (state)
         ST_IDLE: if (bus.src_valid) begin
            load    = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: state_d = ST_READ;
         ST_READ:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.link_ack) begin
               deliver = 1'b1;
               state_d = ST_IDLE;
            end else if (bus.link_nack || (timer == TW'(TIMEOUT - 1))) begin
               if (attempt == AW'(MAX_RETRY)) begin
                  give_up = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  retry   = 1'b1;
                  state_d = ST_WRITE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         inj_q       <= ERR_NONE;
         attempt     <= '0;
         timer       <= '0;
         dlv_valid_q <= 1'b0;
         dlv_data_q  <= '0;
         fail_q      <= 1'b0;
      end else begin
         if (load) begin
            hold_q  <= bus.src_data;
            inj_q   <= bus.inj_mode;
            attempt <= '0;
         end else if (retry) begin
            attempt <= attempt + 1'b1;
         end
         if (state == ST_READ)      timer <= '0;
         else if (state == ST_WAIT) timer <= timer + 1'b1;
         dlv_valid_q <= deliver;
         fail_q      <= give_up;
         if (deliver) dlv_data_q <= bus.link_rx_data;
      end
   end

   assign bus.src_ready     = (state == ST_IDLE);
   assign busy              = (state != ST_IDLE);
   assign bus.link_wr_en    = (state == ST_WRITE);
   assign bus.link_rd_en    = (state == ST_READ);
   // Errors are injected on the first attempt only; retransmissions go out clean.
   assign bus.link_err_mode = (state == ST_READ && attempt == '0) ? inj_q : ERR_NONE;
   assign bus.link_data     = hold_q;
   assign bus.dlv_valid     = dlv_valid_q;
   assign bus.dlv_data      = dlv_data_q;
   assign bus.fail          = fail_q;

`ifdef ARQ_STATS_EN
   arq_sat_counter #(.CNT_W(CNT_W)) u_retry_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retry),
      .count (retry_cnt)
   );

   arq_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (give_up),
      .count (fail_cnt)
   );
`endif

endmodule

// File: tb/tb_arq_tx_ctrl.sv
// Bench for arq_tx_ctrl: a small ECC-core model or response stubs act as the link; each
// accepted word is expanded into a per-cycle expected timeline that one process compares.
module tb_arq_tx_ctrl;
   import arq_pkg::*;

   localparam int DW = 8;
   localparam int TO = 8;
   localparam int MR = 3;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   arq_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();
   logic busy;
`ifdef ARQ_STATS_EN
   logic [CW-1:0] retry_cnt, fail_cnt;
`endif

   arq_tx_ctrl #(
      .DATA_WIDTH(DW), .TIMEOUT(TO), .MAX_RETRY(MR)
`ifdef ARQ_STATS_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master),
      .busy  (busy)
`ifdef ARQ_STATS_EN
      , .retry_cnt (retry_cnt),
      .fail_cnt  (fail_cnt)
`endif
   );

   // Link behaviours: real core, silent, ack+nack together, nack forever.
   typedef enum int {L_CORE, L_SILENT, L_BOTH, L_NACK} link_t;
   link_t   lmode = L_CORE;
   logic [DW-1:0] stub_data = '0;

   // Core model: one-entry store, double errors nack, read result two cycles after rd_en.
   logic [DW-1:0] core_mem, core_p1_data, core_out;
   logic core_p1_ack, core_p1_nack, core_ack, core_nack;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_mem <= '0; core_p1_data <= '0; core_out <= '0;
         core_p1_ack <= 1'b0; core_p1_nack <= 1'b0; core_ack <= 1'b0; core_nack <= 1'b0;
      end else begin
         if (bus.link_wr_en) core_mem <= bus.link_data;
         core_p1_ack  <= bus.link_rd_en && !bus.link_err_mode[1];
         core_p1_nack <= bus.link_rd_en &&  bus.link_err_mode[1];
         core_p1_data <= core_mem;
         core_ack     <= core_p1_ack;
         core_nack    <= core_p1_nack;
         core_out     <= core_p1_data;
      end
   end

   assign bus.link_ack     = (lmode == L_CORE) ? core_ack  : (lmode == L_BOTH);
   assign bus.link_nack    = (lmode == L_CORE) ? core_nack : (lmode == L_BOTH || lmode == L_NACK);
   assign bus.link_rx_data = (lmode == L_CORE) ? core_out  : stub_data;

   int wr_pulses = 0;
   always @(posedge clk) if (bus.link_wr_en) wr_pulses <= wr_pulses + 1;

   int total = 0;
   int bad   = 0;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for one cycle, and the model's architectural view.
   typedef struct {
      bit wr, rd, rdy, bsy, dv, fl;
      bit [1:0] err;
      bit [DW-1:0] dd, ld;
      int rc, fc;
   } exp_t;
   exp_t q[$];
   bit [DW-1:0] m_hold = '0, m_dlv = '0;
   int m_rc = 0, m_fc = 0;
   bit checking = 1'b0;

   function automatic exp_t idle_e();
      exp_t e;
      e = '{default: 0};
      e.rdy = 1'b1; e.dd = m_dlv; e.ld = m_hold; e.rc = m_rc; e.fc = m_fc;
      return e;
   endfunction

   function automatic exp_t busy_e();
      exp_t e;
      e = idle_e();
      e.rdy = 1'b0; e.bsy = 1'b1;
      return e;
   endfunction

   // Expand one accepted word into its cycle-by-cycle expected outputs.
   task automatic build(input bit [DW-1:0] d, input bit [1:0] inj, input link_t mode,
                        input bit [DW-1:0] sd);
      exp_t e;
      int r;
      bit ack;
      m_hold = d;
      for (int a = 0; a <= MR; a++) begin
         if (a > 0 && m_rc < 255) m_rc++;
         e = busy_e(); e.wr = 1'b1; q.push_back(e);
         e = busy_e(); e.rd = 1'b1; e.err = (a == 0) ? inj : 2'b00; q.push_back(e);
         case (mode)
            L_CORE:   begin r = 1;      ack = !(a == 0 && inj[1]); end
            L_SILENT: begin r = TO - 1; ack = 1'b0; end
            L_BOTH:   begin r = 0;      ack = 1'b1; end
            default:  begin r = 0;      ack = 1'b0; end
         endcase
         for (int w = 0; w <= r; w++) q.push_back(busy_e());
         if (ack) begin
            m_dlv = (mode == L_CORE) ? d : sd;
            e = idle_e(); e.dv = 1'b1; q.push_back(e);
            return;
         end
         if (a == MR) begin
            if (m_fc < 255) m_fc++;
            e = idle_e(); e.fl = 1'b1; q.push_back(e);
            return;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && checking) begin
         e = (q.size() != 0) ? q.pop_front() : idle_e();
         chk("src_ready", int'(bus.src_ready),     int'(e.rdy));
         chk("busy",      int'(busy),              int'(e.bsy));
         chk("wr_en",     int'(bus.link_wr_en),    int'(e.wr));
         chk("rd_en",     int'(bus.link_rd_en),    int'(e.rd));
         chk("err_mode",  int'(bus.link_err_mode), int'(e.err));
         chk("link_data", int'(bus.link_data),     int'(e.ld));
         chk("dlv_valid", int'(bus.dlv_valid),     int'(e.dv));
         chk("dlv_data",  int'(bus.dlv_data),      int'(e.dd));
         chk("fail",      int'(bus.fail),          int'(e.fl));
`ifdef ARQ_STATS_EN
         chk("retry_cnt", int'(retry_cnt), e.rc);
         chk("fail_cnt",  int'(fail_cnt),  e.fc);
`endif
      end
   end

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic send(input bit [DW-1:0] d, input bit [1:0] inj, input link_t mode,
                       input bit [DW-1:0] sd);
      drain();
      @(posedge clk); #1;
      lmode = mode; stub_data = sd;
      bus.src_valid = 1'b1; bus.src_data = d; bus.inj_mode = inj;
      @(posedge clk); #1;
      bus.src_valid = 1'b0; bus.src_data = DW'($urandom); bus.inj_mode = 2'($urandom);
      build(d, inj, mode, sd);
   endtask

   // Edges after the handshake until the wanted pulse shows (bounded).
   task automatic latency(input bit want_fail, output int lat);
      lat = 1;
      @(posedge clk); #1;
      while (!(want_fail ? bus.fail : bus.dlv_valid) && lat < 80) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat, w0;
      bus.src_valid = 1'b0; bus.src_data = '0; bus.inj_mode = 2'b00;
      #12;
      chk("rst_src_ready", int'(bus.src_ready), 1);
      chk("rst_busy",      int'(busy), 0);
      chk("rst_dlv_valid", int'(bus.dlv_valid), 0);
      chk("rst_wr_en",     int'(bus.link_wr_en), 0);
      chk("rst_dlv_data",  int'(bus.dlv_data), 0);
      #10 rst_n = 1'b1;
      checking = 1'b1;

      // 1: clean word, 4-cycle latency
      w0 = wr_pulses;
      send(8'hA5, 2'b00, L_CORE, 8'h00);
      latency(1'b0, lat);
      chk("t1_latency", lat, 4);
      chk("t1_data", int'(bus.dlv_data), 8'hA5);
      chk("t1_writes", wr_pulses - w0, 1);
      // 2: single error corrected by the core
      send(8'h3C, 2'b01, L_CORE, 8'h00);
      latency(1'b0, lat);
      chk("t2_latency", lat, 4);
      chk("t2_data", int'(bus.dlv_data), 8'h3C);
      // 3: double error -> nack -> one clean retry
      send(8'h5A, 2'b10, L_CORE, 8'h00);
      latency(1'b0, lat);
      chk("t3_latency", lat, 8);
      chk("t3_data", int'(bus.dlv_data), 8'h5A);
`ifdef ARQ_STATS_EN
      chk("t3_retry_cnt", int'(retry_cnt), 1);
`endif
      // 4: silent link -> four timed-out attempts -> fail
      w0 = wr_pulses;
      send(8'hC3, 2'b00, L_SILENT, 8'h00);
      latency(1'b1, lat);
      chk("t4_latency", lat, 40);
      chk("t4_writes", wr_pulses - w0, 4);
      chk("t4_ready_on_fail", int'(bus.src_ready), 1);
`ifdef ARQ_STATS_EN
      chk("t4_fail_cnt", int'(fail_cnt), 1);
`endif
      @(posedge clk); #1;
      chk("t4_ready_next", int'(bus.src_ready), 1);
      chk("t4_fail_single", int'(bus.fail), 0);
      // 5: ack+nack together counts as ack; nack forever fails after 4 attempts
      send(8'h11, 2'b00, L_BOTH, 8'h77);
      latency(1'b0, lat);
      chk("t5_both_latency", lat, 3);
      chk("t5_both_data", int'(bus.dlv_data), 8'h77);
      w0 = wr_pulses;
      send(8'h22, 2'b00, L_NACK, 8'h00);
      latency(1'b1, lat);
      chk("t5_nack_latency", lat, 12);
      chk("t5_nack_writes", wr_pulses - w0, 4);
      chk("t5_data_held", int'(bus.dlv_data), 8'h77);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         int r;
         link_t m;
         drain();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         r = $urandom_range(0, 9);
         m = (r < 6) ? L_CORE : (r == 6) ? L_SILENT : (r == 7) ? L_BOTH : L_NACK;
         send(DW'($urandom), 2'($urandom_range(0, 2)), m, DW'($urandom));
      end
      drain();

      // 6: reset in the middle of WAIT, checked before any clock edge
      send(8'h99, 2'b00, L_SILENT, 8'h00);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_src_ready", int'(bus.src_ready), 1);
      chk("t6_busy", int'(busy), 0);
      chk("t6_wr_en", int'(bus.link_wr_en), 0);
      chk("t6_rd_en", int'(bus.link_rd_en), 0);
      chk("t6_dlv_valid", int'(bus.dlv_valid), 0);
      chk("t6_fail", int'(bus.fail), 0);
      chk("t6_dlv_data", int'(bus.dlv_data), 0);
      chk("t6_link_data", int'(bus.link_data), 0);
      q.delete();
      m_hold = '0; m_dlv = '0; m_rc = 0; m_fc = 0;
      #2 rst_n = 1'b1;
      send(8'h4E, 2'b00, L_CORE, 8'h00);
      latency(1'b0, lat);
      chk("t6_after_latency", lat, 4);
      chk("t6_after_data", int'(bus.dlv_data), 8'h4E);
      drain();
      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
